// File: rtl/issueq_freelist.sv
// Circular free list of unoccupied issue-queue entry indices.
// Up to four freed indices are accepted per cycle and compacted into the tail.
// Dispatch is offered four indices per cycle from the head, all-or-nothing.
module issueq_freelist #(
  parameter int SIZE_ISSUEQ     = 64,
  parameter int SIZE_ISSUEQ_LOG = 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       freedValid0_i,
  input  logic                       freedValid1_i,
  input  logic                       freedValid2_i,
  input  logic                       freedValid3_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry0_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry1_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry2_i,
  input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry3_i,
  input  logic                       allocReq_i,
  output logic [SIZE_ISSUEQ_LOG-1:0] allocEntry0_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] allocEntry1_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] allocEntry2_o,
  output logic [SIZE_ISSUEQ_LOG-1:0] allocEntry3_o,
  output logic                       allocValid_o,
  output logic                       stall_o,
  output logic [SIZE_ISSUEQ_LOG:0]   freeCount_o
);

  localparam int LANES = 4;

  typedef logic [SIZE_ISSUEQ_LOG-1:0] idx_t;
  typedef logic [SIZE_ISSUEQ_LOG:0]   cnt_t;

  idx_t list_q [SIZE_ISSUEQ];
  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  cnt_t free_count_q, free_count_d;

  logic [LANES-1:0]       freed_valid;
  idx_t                   freed_entry [LANES];
  logic [SIZE_ISSUEQ-1:0] wr_en;
  idx_t                   wr_data [SIZE_ISSUEQ];
  logic [2:0]             n_push;
  logic                   alloc_valid;
  logic                   stall;

  assign freed_valid    = {freedValid3_i, freedValid2_i, freedValid1_i, freedValid0_i};
  assign freed_entry[0] = freedEntry0_i;
  assign freed_entry[1] = freedEntry1_i;
  assign freed_entry[2] = freedEntry2_i;
  assign freed_entry[3] = freedEntry3_i;

  // Read side comes straight from registers; freed indices are never bypassed.
  assign stall         = (free_count_q < cnt_t'(LANES));
  assign alloc_valid   = allocReq_i & ~stall;
  assign allocEntry0_o = list_q[head_q];
  assign allocEntry1_o = list_q[head_q + idx_t'(1)];
  assign allocEntry2_o = list_q[head_q + idx_t'(2)];
  assign allocEntry3_o = list_q[head_q + idx_t'(3)];
  assign allocValid_o  = alloc_valid;
  assign stall_o       = stall;
  assign freeCount_o   = free_count_q;

  // Compact the valid freed lanes in lane order onto consecutive tail slots.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_en   = '0;
    wr_data = '{default: '0};
    n_push  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (freed_valid[k]) begin
        wr_en[tail_q + idx_t'(n_push)]   = 1'b1;
        wr_data[tail_q + idx_t'(n_push)] = freed_entry[k];
        n_push = n_push + 3'd1;
      end
    end
  end

  // Pointer and occupancy next state; pointers wrap naturally at the list depth.
  always_comb begin
    head_d       = alloc_valid ? head_q + idx_t'(LANES) : head_q;
    tail_d       = tail_q + idx_t'(n_push);
    free_count_d = free_count_q + cnt_t'(n_push) - (alloc_valid ? cnt_t'(LANES) : cnt_t'(0));
  end

  // Pointer and count registers; reset leaves the whole list free.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      free_count_q <= cnt_t'(SIZE_ISSUEQ);
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      free_count_q <= free_count_d;
    end
  end

  // One register per slot, reset to its own index so the list starts full.
  // NOTE: this storage is reset on purpose; the identity contents are the free list after reset.
  for (genvar j = 0; j < SIZE_ISSUEQ; j++) begin : g_slot
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)      list_q[j] <= idx_t'(j);
      else if (wr_en[j]) list_q[j] <= wr_data[j];
    end
  end

  // Protocol checks on the freeing logic: overflow, duplicates in a group, re-freeing a free index.
  logic [SIZE_ISSUEQ_LOG+1:0] occupancy_next;
  logic                       dup_in_group;
  logic                       already_free;

  always_comb begin
    occupancy_next = {1'b0, free_count_q} + {{(SIZE_ISSUEQ_LOG-1){1'b0}}, n_push}
                   - (alloc_valid ? (SIZE_ISSUEQ_LOG+2)'(LANES) : '0);
    dup_in_group = 1'b0;
    for (int a = 0; a < LANES; a++)
      for (int b = a + 1; b < LANES; b++)
        if (freed_valid[a] && freed_valid[b] && freed_entry[a] == freed_entry[b])
          dup_in_group = 1'b1;
    already_free = 1'b0;
    for (int j = 0; j < SIZE_ISSUEQ; j++)
      if ({1'b0, idx_t'(j) - head_q} < free_count_q)
        for (int k = 0; k < LANES; k++)
          if (freed_valid[k] && list_q[j] == freed_entry[k])
            already_free = 1'b1;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    occupancy_next <= (SIZE_ISSUEQ_LOG+2)'(SIZE_ISSUEQ));
  a_no_dup_group: assert property (@(posedge clock) disable iff (!reset_n) !dup_in_group);
  a_no_refree:    assert property (@(posedge clock) disable iff (!reset_n) !already_free);

endmodule
